// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one external 32-bit ALU between NREQ requesters. It arbitrates the
//   requests round-robin, registers the winner's operands, runs the ALU for one
//   cycle and holds the result until the owner acknowledges it.
//   FSM: IDLE (grant/accept) -> EXEC (capture ALU outputs) -> RESP (hold) -> IDLE.
// Ports
//   clk, reset              clock; asynchronous active-high reset
//   req_valid/req_ready     per-requester request handshake (req_ready one-hot)
//   req_srcA/req_srcB       packed 32-bit operands, slice i belongs to requester i
//   req_ctrl                packed 3-bit ALU control codes
//   alu_srcA/alu_srcB/alu_ctrl  registered operands driving the ALU
//   alu_out/alu_zero        ALU result inputs
//   resp_valid/resp_ready   per-requester response handshake (resp_valid one-hot)
//   resp_result/resp_zero/resp_err/resp_id  held response, shared by all requesters
module alu_share_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_srcA,
  input  logic [NREQ*32-1:0]   req_srcB,
  input  logic [NREQ*3-1:0]    req_ctrl,
  output logic [31:0]          alu_srcA,
  output logic [31:0]          alu_srcB,
  output logic [2:0]           alu_ctrl,
  input  logic [31:0]          alu_out,
  input  logic                 alu_zero,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [31:0]          resp_result,
  output logic                 resp_zero,
  output logic                 resp_err,
  output logic [IDW-1:0]       resp_id
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  localparam logic [2:0] CtrlUnused = 3'b011;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [31:0]     srca_q, srca_d;
  logic [31:0]     srcb_q, srcb_d;
  logic [2:0]      ctrl_q, ctrl_d;
  logic [31:0]     result_q, result_d;
  logic            zero_q, zero_d;
  logic            err_q, err_d;

  logic [IDW-1:0]  grant_hi, grant_lo, grant;
  logic            found_hi;
  logic            any_valid;
  logic            op_err;

  // Round-robin pick: lowest valid index at or above rr_ptr, else wrap to the
  // lowest valid index overall. Scanning downwards leaves the lowest match.
  always_comb begin
    grant_hi = '0;
    grant_lo = '0;
    found_hi = 1'b0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_lo = IDW'(i);
        if (IDW'(i) >= rr_ptr_q) begin
          grant_hi = IDW'(i);
          found_hi = 1'b1;
        end
      end
    end
    grant = found_hi ? grant_hi : grant_lo;
  end

  assign any_valid = |req_valid;
  assign op_err    = (ctrl_q == CtrlUnused);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    srca_d     = srca_q;
    srcb_d     = srcb_q;
    ctrl_d     = ctrl_q;
    result_d   = result_q;
    zero_d     = zero_q;
    err_d      = err_q;
    req_ready  = '0;
    resp_valid = '0;
    case (state_q)
      StIdle: begin
        if (any_valid) begin
          req_ready[grant] = 1'b1;
          srca_d  = req_srcA[grant*32 +: 32];
          srcb_d  = req_srcB[grant*32 +: 32];
          ctrl_d  = req_ctrl[grant*3 +: 3];
          owner_d = grant;
          state_d = StExec;
        end
      end
      StExec: begin
        // Unused code: the ALU output is undefined, so report a clean zero.
        result_d = op_err ? 32'd0 : alu_out;
        zero_d   = op_err ? 1'b1 : alu_zero;
        err_d    = op_err;
        state_d  = StResp;
      end
      StResp: begin
        resp_valid[owner_q] = 1'b1;
        if (resp_ready[owner_q]) begin
          state_d  = StIdle;
          rr_ptr_d = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      srca_q   <= '0;
      srcb_q   <= '0;
      ctrl_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      srca_q   <= srca_d;
      srcb_q   <= srcb_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign alu_srcA    = srca_q;
  assign alu_srcB    = srcb_q;
  assign alu_ctrl    = ctrl_q;
  assign resp_result = result_q;
  assign resp_zero   = zero_q;
  assign resp_err    = err_q;
  assign resp_id     = owner_q;

endmodule
